// File: rtl/systolic_pkg.sv
// Shared fixed-point constants, vector types and the saturating requantizer used
// by the stages behind the systolic array.
package systolic_pkg;

  localparam int SYSTOLIC_ARRAY_COLS  = 8;
  localparam int FIXED_POINT_WIDTH    = 16;
  localparam int FIXED_POINT_POSITION = 10;
  localparam int PARTIAL_SUM_WIDTH    = FIXED_POINT_WIDTH + 7;
  localparam int FIFO_DEPTH           = 4;

  typedef logic [SYSTOLIC_ARRAY_COLS-1:0][FIXED_POINT_WIDTH-1:0] out_vec_t;

  typedef struct packed {
    logic [FIXED_POINT_WIDTH-1:0] value;
    logic                         clipped;
  } sat_result_t;

  localparam logic signed [PARTIAL_SUM_WIDTH-1:0] SAT_MAX =
    {{(PARTIAL_SUM_WIDTH-FIXED_POINT_WIDTH+1){1'b0}}, {(FIXED_POINT_WIDTH-1){1'b1}}};
  localparam logic signed [PARTIAL_SUM_WIDTH-1:0] SAT_MIN =
    {{(PARTIAL_SUM_WIDTH-FIXED_POINT_WIDTH+1){1'b1}}, {(FIXED_POINT_WIDTH-1){1'b0}}};

  // Input and output share the binary point, so only the range is clipped.
  function automatic sat_result_t saturate(input logic signed [PARTIAL_SUM_WIDTH-1:0] sum);
    sat_result_t res;
    if (sum > SAT_MAX) begin
      res.value   = {1'b0, {(FIXED_POINT_WIDTH-1){1'b1}}};
      res.clipped = 1'b1;
    end else if (sum < SAT_MIN) begin
      res.value   = {1'b1, {(FIXED_POINT_WIDTH-1){1'b0}}};
      res.clipped = 1'b1;
    end else begin
      res.value   = sum[FIXED_POINT_WIDTH-1:0];
      res.clipped = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/systolic_output_deskew_fifo.sv
// First-word fall-through FIFO with a registered head; the head holds its last
// value once the FIFO drains.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] push_data_in,
  input  logic             pop_in,
  output logic [WIDTH-1:0] head_data_out,
  output logic             valid_out,
  output logic             full_out
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [WIDTH-1:0] head_r;
  logic             valid_r;
  logic             full_r;

  logic             pop_s;
  logic             push_s;
  logic [AW-1:0]    rd_ptr_nxt_s;
  logic [AW:0]      left_s;
  logic [AW:0]      count_nxt_s;

  // Qualify push/pop and derive next pointer and occupancy.
  always_comb begin
    pop_s        = pop_in && (count_r != {(AW+1){1'b0}});
    push_s       = push_in && ((count_r != (AW+1)'(DEPTH)) || pop_s);
    rd_ptr_nxt_s = pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
    left_s       = pop_s ? count_r - (AW+1)'(1) : count_r;
    count_nxt_s  = push_s ? left_s + (AW+1)'(1) : left_s;
  end

  // Storage array; only occupied slots are ever read, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data_in;
    end
  end

  // Pointers, occupancy and the registered head/flags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      head_r   <= {WIDTH{1'b0}};
      valid_r  <= 1'b0;
      full_r   <= 1'b0;
    end else begin
      wr_ptr_r <= push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      valid_r  <= (count_nxt_s != {(AW+1){1'b0}});
      full_r   <= (count_nxt_s == (AW+1)'(DEPTH));
      // A push into a FIFO that would otherwise be empty bypasses the array.
      if (count_nxt_s == {(AW+1){1'b0}}) begin
        head_r <= head_r;
      end else if (left_s == {(AW+1){1'b0}}) begin
        head_r <= push_data_in;
      end else begin
        head_r <= mem_r[rd_ptr_nxt_s];
      end
    end
  end

  assign head_data_out = head_r;
  assign valid_out     = valid_r;
  assign full_out      = full_r;

endmodule

// File: rtl/systolic_output_deskew.sv
// Re-aligns staggered column sums from the systolic array, saturates each lane
// and buffers whole vectors toward write-back; waves hitting a full buffer are dropped.
module systolic_output_deskew
  import systolic_pkg::*;
#(
  parameter int COLS  = SYSTOLIC_ARRAY_COLS,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                                    clk_in,
  input  logic                                    rst_in,
  input  logic                                    sum_valid_in,
  input  logic [COLS-1:0][PARTIAL_SUM_WIDTH-1:0]  sum_in,
  output logic                                    out_valid_out,
  input  logic                                    out_ready_in,
  output logic [COLS-1:0][FIXED_POINT_WIDTH-1:0]  data_out,
  output logic [COLS-1:0]                         saturated_out,
  output logic                                    overflow_out
);

  localparam int FW = COLS * FIXED_POINT_WIDTH + COLS;

  logic [COLS-2:0]                        vld_r;
  logic [PARTIAL_SUM_WIDTH-1:0]           aligned_s [COLS];
  sat_result_t                            sat_res_s [COLS];
  logic [COLS-1:0][FIXED_POINT_WIDTH-1:0] sat_data_s;
  logic [COLS-1:0]                        sat_flag_s;
  logic                                   wave_s;
  logic                                   pop_s;
  logic                                   fifo_full_s;
  logic                                   overflow_r;
  logic [FW-1:0]                          head_s;

  // Column c is delayed COLS-1-c cycles so every lane lines up with the last one.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    if (c == COLS - 1) begin : g_direct
      assign aligned_s[c] = sum_in[c];
    end else begin : g_dly
      logic [PARTIAL_SUM_WIDTH-1:0] dly_r [COLS-1-c];
      // Per-column delay line.
      always_ff @(posedge clk_in) begin
        dly_r[0] <= sum_in[c];
        for (int i = 1; i < COLS - 1 - c; i++) begin
          dly_r[i] <= dly_r[i-1];
        end
      end
      assign aligned_s[c] = dly_r[COLS-2-c];
    end
  end

  // Valid tag travels alongside column 0 of each wave.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_r <= '0;
    end else begin
      vld_r[0] <= sum_valid_in;
      for (int i = 1; i < COLS - 1; i++) begin
        vld_r[i] <= vld_r[i-1];
      end
    end
  end

  // Saturate the aligned vector lane by lane.
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      sat_res_s[c]  = saturate($signed(aligned_s[c]));
      sat_data_s[c] = sat_res_s[c].value;
      sat_flag_s[c] = sat_res_s[c].clipped;
    end
  end

  assign wave_s = vld_r[COLS-2];
  assign pop_s  = out_valid_out && out_ready_in;

  // Sticky drop flag: a full buffer only loses a wave if nothing leaves that cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      overflow_r <= 1'b0;
    end else if (wave_s && fifo_full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .push_in       (wave_s),
    .push_data_in  ({sat_flag_s, sat_data_s}),
    .pop_in        (pop_s),
    .head_data_out (head_s),
    .valid_out     (out_valid_out),
    .full_out      (fifo_full_s)
  );

  assign {saturated_out, data_out} = head_s;
  assign overflow_out              = overflow_r;

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Self-checking bench: table vectors, directed corner sequences and random traffic
// against a queue-based reference model of the deskew/saturate/FIFO behaviour.
module tb_systolic_output_deskew;
  import systolic_pkg::*;

  localparam int COLS  = 8;
  localparam int W     = 16;
  localparam int PSW   = 23;
  localparam int DEPTH = 4;

  typedef logic [COLS-1:0][PSW-1:0] raw_t;
  typedef struct packed {
    logic [COLS-1:0]        sat;
    logic [COLS-1:0][W-1:0] data;
  } ent_t;
  typedef struct {
    raw_t                   raw;
    logic [COLS-1:0][W-1:0] exp_data;
    logic [COLS-1:0]        exp_sat;
  } vec_rec_t;

  logic                   clk_in = 1'b0;
  logic                   rst_in = 1'b1;
  logic                   sum_valid_in = 1'b0;
  raw_t                   sum_in = '0;
  logic                   out_valid_out;
  logic                   out_ready_in = 1'b0;
  logic [COLS-1:0][W-1:0] data_out;
  logic [COLS-1:0]        saturated_out;
  logic                   overflow_out;

  always #5 clk_in = ~clk_in;

  systolic_output_deskew dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .sum_valid_in  (sum_valid_in),
    .sum_in        (sum_in),
    .out_valid_out (out_valid_out),
    .out_ready_in  (out_ready_in),
    .data_out      (data_out),
    .saturated_out (saturated_out),
    .overflow_out  (overflow_out)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  raw_t launch_q [int];
  ent_t mq [$];
  ent_t last_e = '0;
  bit   exp_ovf = 1'b0;
  bit   obs_valid [int];
  bit   obs_ovf [int];
  ent_t obs_head [int];
  ent_t got_q [$];
  vec_rec_t tbl [3];
  raw_t w [5];

  function automatic ent_t ref_sat(input raw_t r);
    ent_t e;
    longint v;
    for (int c = 0; c < COLS; c++) begin
      v = longint'($signed(r[c]));
      if (v > 32767) begin
        e.data[c] = 16'h7FFF; e.sat[c] = 1'b1;
      end else if (v < -32768) begin
        e.data[c] = 16'h8000; e.sat[c] = 1'b1;
      end else begin
        e.data[c] = 16'(v); e.sat[c] = 1'b0;
      end
    end
    return e;
  endfunction

  function automatic raw_t rand_raw();
    raw_t r;
    for (int c = 0; c < COLS; c++) begin
      if ($urandom_range(0, 1) == 0) r[c] = PSW'($urandom);
      else r[c] = PSW'(int'($urandom_range(0, 80000)) - 40000);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic step(input bit rdy, input bit rst);
    ent_t exp_head;
    ent_t got;
    int   keys [$];
    bit   pop;
    out_ready_in = rdy;
    rst_in       = rst;
    sum_valid_in = launch_q.exists(cyc);
    for (int c = 0; c < COLS; c++) begin
      if (launch_q.exists(cyc - c)) sum_in[c] = launch_q[cyc - c][c];
      else sum_in[c] = PSW'($urandom);
    end
    @(negedge clk_in);
    exp_head = (mq.size() > 0) ? mq[0] : last_e;
    got = {saturated_out, data_out};
    obs_valid[cyc] = out_valid_out;
    obs_ovf[cyc]   = overflow_out;
    obs_head[cyc]  = got;
    if (chk_en) begin
      check("valid", out_valid_out, mq.size() > 0);
      check("data", data_out, exp_head.data);
      check("sat", saturated_out, exp_head.sat);
      check("overflow", overflow_out, exp_ovf);
    end
    if (out_valid_out && rdy && !rst) got_q.push_back(got);
    last_e = exp_head;
    if (rst) begin
      mq.delete();
      exp_ovf = 1'b0;
      last_e  = '0;
      foreach (launch_q[k]) if (k <= cyc) keys.push_back(k);
      foreach (keys[i]) launch_q.delete(keys[i]);
    end else begin
      pop = (mq.size() > 0) && rdy;
      if (pop) void'(mq.pop_front());
      if (launch_q.exists(cyc - (COLS - 1))) begin
        if (mq.size() < DEPTH) mq.push_back(ref_sat(launch_q[cyc - (COLS - 1)]));
        else exp_ovf = 1'b1;
      end
    end
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  initial begin
    int b;
    int c2;
    for (int c = 0; c < COLS; c++) begin
      tbl[0].raw[c] = PSW'(c * 1024);
      tbl[0].exp_data[c] = W'(c * 1024);
    end
    tbl[0].exp_sat = 8'h00;
    tbl[1].raw = {23'd0 - 23'd1, 23'h3FFFFF, 23'd0 - 23'd32769, 23'd0 - 23'd32768,
                  23'd32768, 23'h007FFF, 23'd0 - 23'd1048576, 23'd1048576};
    tbl[1].exp_data = {16'hFFFF, 16'h7FFF, 16'h8000, 16'h8000,
                       16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF};
    tbl[1].exp_sat = 8'h6B;
    tbl[2].raw = {23'd0, 23'd0 - 23'd40000, 23'd40000, 23'd12345,
                  23'h400000, 23'd32767, 23'd0 - 23'd1000, 23'd1000};
    tbl[2].exp_data = {16'h0000, 16'h8000, 16'h7FFF, 16'h3039,
                       16'h8000, 16'h7FFF, 16'hFC18, 16'h03E8};
    tbl[2].exp_sat = 8'h68;

    @(posedge clk_in);
    #1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk_en = 1'b1;
    step(1'b0, 1'b0);
    check("reset_valid", obs_valid[cyc-1], 1'b0);
    check("reset_head", obs_head[cyc-1], 136'd0);
    check("reset_ovf", obs_ovf[cyc-1], 1'b0);

    // Single-wave vectors: valid exactly COLS cycles after launch.
    foreach (tbl[e]) begin
      b = cyc;
      launch_q[cyc] = tbl[e].raw;
      for (int t = 0; t < COLS + 3; t++) step(1'b1, 1'b0);
      check("tbl_early", obs_valid[b+COLS-1], 1'b0);
      check("tbl_valid", obs_valid[b+COLS], 1'b1);
      check("tbl_late", obs_valid[b+COLS+1], 1'b0);
      check("tbl_data", obs_head[b+COLS].data, tbl[e].exp_data);
      check("tbl_sat", obs_head[b+COLS].sat, tbl[e].exp_sat);
      check("tbl_hold", obs_head[b+COLS+2].data, tbl[e].exp_data);
    end

    // Back-to-back waves.
    b = cyc;
    for (int t = 0; t < 14; t++) begin
      if (t < 3) begin w[t] = rand_raw(); launch_q[cyc] = w[t]; end
      step(1'b1, 1'b0);
    end
    check("b2b_pre", obs_valid[b+7], 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("b2b_valid", obs_valid[b+8+i], 1'b1);
      check("b2b_data", obs_head[b+8+i], ref_sat(w[i]));
    end
    check("b2b_post", obs_valid[b+11], 1'b0);

    // Backpressure: fifth wave dropped, overflow sticky.
    b = cyc;
    got_q.delete();
    for (int t = 0; t < 16; t++) begin
      if (t < 5) begin w[t] = rand_raw(); launch_q[cyc] = w[t]; end
      step(1'b0, 1'b0);
    end
    for (int t = 0; t < 8; t++) step(1'b1, 1'b0);
    check("bp_ovf_before", obs_ovf[b+11], 1'b0);
    check("bp_ovf_rise", obs_ovf[b+13], 1'b1);
    check("bp_ovf_stay", obs_ovf[cyc-1], 1'b1);
    check("bp_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check("bp_order", got_q[i], ref_sat(w[i]));
    step(1'b0, 1'b1);

    // Full with simultaneous pop in the cycle the fifth wave writes.
    b = cyc;
    got_q.delete();
    for (int t = 0; t < 20; t++) begin
      if (t < 5) begin w[t] = rand_raw(); launch_q[cyc] = w[t]; end
      step((t == 11) || (t >= 14), 1'b0);
    end
    check("fp_ovf", obs_ovf[cyc-1], 1'b0);
    check("fp_count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) check("fp_order", got_q[i], ref_sat(w[i]));

    // Reset while a wave is in flight.
    b = cyc;
    launch_q[cyc] = rand_raw();
    for (int t = 0; t <= 20; t++) step(1'b1, t == 4);
    for (int t = 5; t <= 20; t++) check("rst_no_valid", obs_valid[b+t], 1'b0);
    check("rst_ovf", obs_ovf[b+20], 1'b0);
    c2 = cyc;
    w[0] = rand_raw();
    launch_q[cyc] = w[0];
    for (int t = 0; t < 10; t++) step(1'b1, 1'b0);
    check("post_rst_early", obs_valid[c2+7], 1'b0);
    check("post_rst_valid", obs_valid[c2+8], 1'b1);
    check("post_rst_data", obs_head[c2+8], ref_sat(w[0]));

    // Random traffic against the reference model.
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 1) == 1) launch_q[cyc] = rand_raw();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    end
    for (int t = 0; t < 20; t++) step(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
